// File: rtl/spi_flash_ahb_master_if.sv
// Request port and AHB-Lite master/slave signals of spi_flash_ahb_master.
// The master modport is the DUT's view; the slave modport is the requester plus bus model.
interface spi_flash_ahb_master_if;
  // Request handshake: a request transfers on a rising edge where
  // i_valid && o_ready. The requester holds i_addr/i_wr_data/i_rd0_wr1
  // stable from i_valid rising until that edge.
  logic        i_valid;
  logic        o_ready;
  logic [31:0] i_addr;
  logic [31:0] i_wr_data;
  logic        i_rd0_wr1;
  logic        o_done;
  logic        o_rd_valid;
  logic [31:0] o_rd_data;
  logic        o_err;
  logic        o_timeout;
  logic [31:0] o_err_addr;
  logic        i_err_clr;
  logic [31:0] o_haddr;
  logic [1:0]  o_htrans;
  logic        o_hwrite;
  logic [2:0]  o_hsize;
  logic [2:0]  o_hburst;
  logic [31:0] o_hwdata;
  logic [31:0] i_hrdata;
  logic        i_hready;
  logic        i_hresp;

  modport master (
    input  i_valid, i_addr, i_wr_data, i_rd0_wr1, i_err_clr,
    input  i_hrdata, i_hready, i_hresp,
    output o_ready, o_done, o_rd_valid, o_rd_data, o_err, o_timeout, o_err_addr,
    output o_haddr, o_htrans, o_hwrite, o_hsize, o_hburst, o_hwdata
  );

  modport slave (
    output i_valid, i_addr, i_wr_data, i_rd0_wr1, i_err_clr,
    output i_hrdata, i_hready, i_hresp,
    input  o_ready, o_done, o_rd_valid, o_rd_data, o_err, o_timeout, o_err_addr,
    input  o_haddr, o_htrans, o_hwrite, o_hsize, o_hburst, o_hwdata
  );
endinterface

// File: rtl/spi_flash_ahb_master.sv
// Single-transfer AHB-Lite master: one NONSEQ/SINGLE word transfer per request,
// with wait states, two-cycle ERROR response and a data-phase timeout.
module spi_flash_ahb_master #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                          ahbclk,
  input  logic                          ahbrst,
  spi_flash_ahb_master_if.master        bus,
  output logic [1:0]                    o_dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_ERR2 = 2'd3
  } state_e;

  localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT);
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        write_q, write_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        done_q, done_d;
  logic        rd_valid_q, rd_valid_d;
  logic [31:0] rd_data_q, rd_data_d;
  logic        err_q, err_d;
  logic        tmo_q, tmo_d;
  logic [31:0] err_addr_q, err_addr_d;
  logic        err_set, tmo_set;
  logic        accept;

  always_ff @(posedge ahbclk or negedge ahbrst) begin
    if (!ahbrst) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      write_q    <= 1'b0;
      cnt_q      <= '0;
      done_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      err_q      <= 1'b0;
      tmo_q      <= 1'b0;
      err_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      write_q    <= write_d;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      err_q      <= err_d;
      tmo_q      <= tmo_d;
      err_addr_q <= err_addr_d;
    end
  end

  assign accept = bus.i_valid && (state_q == ST_IDLE);

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    write_d    = write_q;
    cnt_d      = cnt_q;
    done_d     = 1'b0;
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data_q;
    err_addr_d = err_addr_q;
    err_set    = 1'b0;
    tmo_set    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          addr_d  = bus.i_addr;
          write_d = bus.i_rd0_wr1;
          // Write data is only replaced by a write, so HWDATA stays quiet on reads.
          if (bus.i_rd0_wr1) wdata_d = bus.i_wr_data;
          if (bus.i_addr[1:0] != 2'b00) begin
            done_d     = 1'b1;
            err_set    = 1'b1;
            err_addr_d = bus.i_addr;
          end else begin
            state_d = ST_ADDR;
          end
        end
      end
      ST_ADDR: begin
        if (bus.i_hready) begin
          state_d = ST_DATA;
          cnt_d   = '0;
        end
      end
      ST_DATA: begin
        if (bus.i_hresp) begin
          if (bus.i_hready) begin
            // Single-cycle ERROR is illegal on AHB-Lite; still report it as a failure.
            state_d    = ST_IDLE;
            done_d     = 1'b1;
            err_set    = 1'b1;
            err_addr_d = addr_q;
          end else begin
            state_d = ST_ERR2;
          end
        end else if (bus.i_hready) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          if (!write_q) begin
            rd_data_d  = bus.i_hrdata;
            rd_valid_d = 1'b1;
          end
        end else if (cnt_q + 8'd1 == TMO_LIMIT) begin
          state_d    = ST_IDLE;
          done_d     = 1'b1;
          err_set    = 1'b1;
          tmo_set    = 1'b1;
          err_addr_d = addr_q;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_ERR2: begin
        if (bus.i_hready) begin
          state_d    = ST_IDLE;
          done_d     = 1'b1;
          err_set    = 1'b1;
          err_addr_d = addr_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A new error event outranks a clear in the same cycle.
    err_d = err_set ? 1'b1 : (bus.i_err_clr ? 1'b0 : err_q);
    tmo_d = tmo_set ? 1'b1 : (bus.i_err_clr ? 1'b0 : tmo_q);
  end

  assign bus.o_ready    = (state_q == ST_IDLE);
  assign bus.o_htrans   = (state_q == ST_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign bus.o_haddr    = addr_q;
  assign bus.o_hwrite   = write_q;
  assign bus.o_hsize    = 3'b010;
  assign bus.o_hburst   = 3'b000;
  assign bus.o_hwdata   = wdata_q;
  assign bus.o_done     = done_q;
  assign bus.o_rd_valid = rd_valid_q;
  assign bus.o_rd_data  = rd_data_q;
  assign bus.o_err      = err_q;
  assign bus.o_timeout  = tmo_q;
  assign bus.o_err_addr = err_addr_q;
  assign o_dbg_state    = state_q;

endmodule
